// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side word packer: defaults, FSM states
// and the byte-count width helper.
package fifo_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int PACK_DEFAULT  = 4;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    WAIT_OUT = 2'd1,
    FLUSH    = 2'd2
  } pk_state_e;

  // Width needed to hold a byte count from 0 to pack inclusive.
  function automatic int cnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_word_packer_acc.sv
// Byte accumulator: writes the landing byte at slot acc_cnt, keeps the fill
// count, and zero-fills every lane on clear so partial words carry no stale data.
module pack_acc
  import fifo_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEFAULT,
  parameter int  PACK  = PACK_DEFAULT,
  localparam int CW    = cnt_width(PACK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clr,
  output logic [CW-1:0]         acc_cnt,
  output logic [WIDTH*PACK-1:0] acc_word
);

  logic [WIDTH*PACK-1:0] data_q, data_d, merged;
  logic [CW-1:0]         cnt_q, cnt_d;

  // acc_word includes this cycle's landing byte so a completing word can be
  // handed to the output register without waiting a cycle.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    merged = data_q;
    for (int i = 0; i < PACK; i++) begin
      if (wr_en && (cnt_q == CW'(i))) merged[i*WIDTH +: WIDTH] = wr_data;
    end
    data_d = clr ? '0 : merged;
    cnt_d  = clr ? '0 : cnt_q + CW'(wr_en);
  end

  // NOTE: the data lanes are reset too, because unfilled lanes must read as zero.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc_cnt  = cnt_q;
  assign acc_word = merged;

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from a one-cycle-latency FIFO, packs PACK of them little-endian
// into a word and offers it on a valid/ready stream; flush emits a partial word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEFAULT,
  parameter int  PACK  = PACK_DEFAULT,
  localparam int CW    = cnt_width(PACK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [WIDTH-1:0]      fifo_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH*PACK-1:0] m_data,
  output logic [CW-1:0]         m_count
);

  localparam logic [CW:0]   PACK_W = (CW+1)'(PACK);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  pk_state_e             state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  m_valid_q, m_valid_d;
  logic [WIDTH*PACK-1:0] m_data_q, m_data_d;
  logic [CW-1:0]         m_count_q, m_count_d;

  logic [CW-1:0]         acc_cnt;
  logic [WIDTH*PACK-1:0] acc_word;
  logic [CW:0]           commit;
  logic                  out_free, completes, acc_clr, rd_en;

  pack_acc #(.WIDTH(WIDTH), .PACK(PACK)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (pending_q),
    .wr_data  (fifo_data),
    .clr      (acc_clr),
    .acc_cnt  (acc_cnt),
    .acc_word (acc_word)
  );

  assign commit    = {1'b0, acc_cnt} + (CW+1)'(pending_q);
  assign out_free  = !m_valid_q || m_ready;
  assign completes = pending_q && (commit == PACK_W);

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    acc_clr   = 1'b0;
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_count_d = m_count_q;

    case (state_q)
      FILL: begin
        if (flush) begin
          state_d = FLUSH;
        end else begin
          rd_en = !fifo_empty && ((commit < PACK_W) || ((commit == PACK_W) && out_free));
        end
        // A byte already in flight still lands in the flush cycle.
        if (completes) begin
          if (out_free) begin
            m_valid_d = 1'b1;
            m_data_d  = acc_word;
            m_count_d = PACK_C;
            acc_clr   = 1'b1;
          end else if (!flush) begin
            state_d = WAIT_OUT;
          end
        end
      end
      WAIT_OUT: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = acc_word;
          m_count_d = PACK_C;
          acc_clr   = 1'b1;
          state_d   = FILL;
        end
      end
      FLUSH: begin
        if (!pending_q) begin
          if (acc_cnt == '0) begin
            state_d = FILL;
          end else if (out_free) begin
            m_valid_d = 1'b1;
            m_data_d  = acc_word;
            m_count_d = acc_cnt;
            acc_clr   = 1'b1;
            state_d   = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase

    if (!rst) rd_en = 1'b0;
    pending_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FILL;
      pending_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_count_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_count_q <= m_count_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_count    = m_count_q;

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side stage directly downstream of the byte FIFO. Pops bytes from the FIFO, packs `PACK` consecutive bytes into one word, and presents words on a valid/ready stream. Supports a flush request that emits a partial word. Sustains one byte per cycle when the sink never stalls.

## Interface
- `WIDTH`, 8, FIFO byte width.
- `PACK`, 4, bytes per output word; must be ≥2.
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO pop request. Combinational.
- `fifo_data` in `WIDTH`: FIFO registered read data. Valid the cycle after an accepted pop.
- `flush` in 1: single-cycle request to emit the bytes accumulated so far.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: sink accepts the word.
- `m_data` out `WIDTH*PACK`: packed word.
- `m_count` out `$clog2(PACK+1)`: number of valid bytes in `m_data`, from 1 to `PACK`.

## Operation
- **FIFO read latency is one cycle.**
  - If `fifo_rd_en` is high in cycle N, a `pending` flag is set for cycle N+1.
  - In cycle N+1, `fifo_data` is written into the accumulator at slot `acc_cnt`.
- **Byte order is little-endian.** The first byte popped goes to `m_data[WIDTH-1:0]`. Unfilled byte lanes are zero.
- **Committed count:** `commit = acc_cnt + pending`.
- **`fifo_rd_en` is high only when all of the following hold:**
  - the state is FILL, and
  - `!fifo_empty`, and
  - either `commit < PACK`, or the word completes this cycle (`commit == PACK`) and `out_free` is true.
- **`out_free`** is defined as `!m_valid || m_ready`.
- **Word completion:** when the landing byte makes `acc_cnt` reach `PACK`, the word moves to the output register in the same cycle, provided `out_free` holds.
  - The accumulator then clears to zero.
  - `m_count` is set to `PACK`.
  - If `out_free` is false, the full word waits in the accumulator (state WAIT_OUT).
- **Output register:** once `m_valid` is high, `m_data` and `m_count` are held stable until `m_valid && m_ready`. `m_valid` drops after that handshake unless a new word loads in the same cycle.
- **State machine:**
  - FILL: normal operation.
    - Go to WAIT_OUT when the accumulator is full and `!out_free`.
    - Go to FLUSH when `flush` is seen.
  - WAIT_OUT: no reads are issued. When `out_free`, load the word, clear the accumulator, and return to FILL.
  - FLUSH: no new reads are issued. Wait until `pending` is 0.
    - If `acc_cnt > 0` and `out_free`: load the partial word with `m_count = acc_cnt`, then return to FILL.
    - If `acc_cnt == 0`: return to FILL with no output.
- **`flush` priority rules:**
  - `flush` is ignored while the state is FLUSH or WAIT_OUT.
  - In FILL, `flush` has priority over a new pop: `fifo_rd_en` is low in the flush cycle. A byte already pending still lands.

## Timing
- **Reset values** (`rst` low at a clock edge):
  - outputs: `m_valid` 0, `m_data` 0, `m_count` 0;
  - internal: `acc_cnt` 0, `pending` 0, state FILL.
  - `fifo_rd_en` is forced to 0 while `rst` is low.
- **Mid-operation reset:** a reset during operation discards any pending byte, the accumulator contents and the output word. The FIFO's own pointers are not affected.
- **Latency:** the last byte of a word is popped in cycle N, `fifo_data` is valid in cycle N+1, and `m_valid` is high from cycle N+2.
- **Throughput:** with `m_ready` held high and the FIFO never empty, `fifo_rd_en` stays high every cycle and one word is produced every `PACK` cycles.
- **FIFO empty:** no pop is issued and the accumulator holds its contents indefinitely. No timeout.
- **Simultaneous events:** a word completion and an output handshake in the same cycle are handled back-to-back with no bubble.

## Structure
- Shared package `fifo_pkg` contains:
  - the `WIDTH` default,
  - `PACK_DEFAULT`,
  - the state enum `pk_state_e` {FILL, WAIT_OUT, FLUSH},
  - the count width function.
- One sub-module, `pack_acc`: the byte accumulator, with the slot write, `acc_cnt`, and the clear and zero-fill logic. FSM and output register stay at top level.

## Test plan
- **Basic pack:** reset, then FIFO supplies 0x11, 0x22, 0x33, 0x44 with `m_ready`=1.
  - Required: `m_data`=0x44332211, `m_count`=4.
  - Required: `m_valid` rises 2 cycles after the 4th `fifo_rd_en`.
- **Streaming:** 8 consecutive bytes 0x01–0x08 with `m_ready`=1.
  - Required: `fifo_rd_en` high 8 consecutive cycles.
  - Required: words 0x04030201 then 0x08070605, exactly 4 cycles apart.
- **Backpressure:** `m_ready`=0 while 12 bytes are available.
  - Required: the first word is held stable, the second word fills the accumulator, reads stop after 8 pops, and state is WAIT_OUT.
  - Then raise `m_ready`: both words delivered in order and reads resume.
- **Partial flush:** bytes 0xAA, 0xBB, then a one-cycle `flush` while the 0xBB pop is still pending.
  - Required: `m_data`=0x0000BBAA, `m_count`=2.
- **Empty flush:** `flush` with `acc_cnt`=0. Required: no `m_valid` pulse and a return to FILL.
- **Reset mid-word:** pop 3 bytes, then assert `rst` low for 1 cycle.
  - Required: all outputs 0.
  - Required: the next 4 bytes form a clean word with no stale lanes.
